// File: rtl/r32_mem_port.sv
// R32 memory port: buffered in-order request channel with read-credit
// flow control and a response FIFO toward the core.
module r32_mem_port #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int REQ_DEPTH = 4,
    parameter int MAX_RD    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_data,
    output logic              m_write,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err
);
    localparam int QA = $clog2(REQ_DEPTH);
    localparam int RA = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
    localparam int CW = $clog2(MAX_RD + 1);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              qmem_q [REQ_DEPTH];
    logic [QA:0]       qwp_q, qwp_d, qrp_q, qrp_d;
    logic [DATA_W-1:0] rmem_q [MAX_RD];
    logic [RA-1:0]     rwi_q, rwi_d, rri_q, rri_d;
    logic              rwph_q, rwph_d, rrph_q, rrph_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic              err_q, err_d;

    req_t head;
    logic q_empty, q_full, r_empty, r_full;
    logic push, issue, rd_issue, s_hit, rsp_pop;

    function automatic logic [RA-1:0] r_inc(input logic [RA-1:0] i);
        return (i == RA'(MAX_RD - 1)) ? '0 : i + RA'(1);
    endfunction

    assign head    = qmem_q[qrp_q[QA-1:0]];
    assign q_empty = (qwp_q == qrp_q);
    assign q_full  = (qwp_q[QA] != qrp_q[QA]) &&
                     (qwp_q[QA-1:0] == qrp_q[QA-1:0]);
    assign r_empty = (rwi_q == rri_q) && (rwph_q == rrph_q);
    assign r_full  = (rwi_q == rri_q) && (rwph_q != rrph_q);

    assign req_ready = reset & ~q_full;
    assign push      = req_valid & req_ready;

    // A read at the head waits for credit and holds everything behind it.
    assign m_valid   = reset & ~q_empty &
                       (head.wr | (credit_q < CW'(MAX_RD)));
    assign m_address = reset ? head.addr : '0;
    assign m_data    = reset ? head.data : '0;
    assign m_write   = reset ? head.wr : 1'b0;
    assign issue     = m_valid & m_ready;
    assign rd_issue  = issue & ~head.wr;

    assign s_ready   = reset & ~r_full;
    assign s_hit     = s_valid & s_ready & (inflight_q != '0);
    assign rsp_valid = reset & ~r_empty;
    assign rsp_data  = rmem_q[rri_q];
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign err       = err_q;

    always_comb begin
        qwp_d      = qwp_q;
        qrp_d      = qrp_q;
        rwi_d      = rwi_q;
        rwph_d     = rwph_q;
        rri_d      = rri_q;
        rrph_d     = rrph_q;
        credit_d   = credit_q;
        inflight_d = inflight_q;
        err_d      = err_q;
        if (push)
            qwp_d = qwp_q + (QA+1)'(1);
        if (issue)
            qrp_d = qrp_q + (QA+1)'(1);
        if (s_hit) begin
            rwi_d = r_inc(rwi_q);
            if (rwi_q == RA'(MAX_RD - 1))
                rwph_d = ~rwph_q;
        end
        if (rsp_pop) begin
            rri_d = r_inc(rri_q);
            if (rri_q == RA'(MAX_RD - 1))
                rrph_d = ~rrph_q;
        end
        if (rd_issue && !rsp_pop)
            credit_d = credit_q + CW'(1);
        else if (!rd_issue && rsp_pop)
            credit_d = credit_q - CW'(1);
        if (rd_issue && !s_hit)
            inflight_d = inflight_q + CW'(1);
        else if (!rd_issue && s_hit)
            inflight_d = inflight_q - CW'(1);
        if (s_valid && inflight_q == '0)
            err_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            qwp_q      <= '0;
            qrp_q      <= '0;
            rwi_q      <= '0;
            rwph_q     <= 1'b0;
            rri_q      <= '0;
            rrph_q     <= 1'b0;
            credit_q   <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            qwp_q      <= qwp_d;
            qrp_q      <= qrp_d;
            rwi_q      <= rwi_d;
            rwph_q     <= rwph_d;
            rri_q      <= rri_d;
            rrph_q     <= rrph_d;
            credit_q   <= credit_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            qmem_q[qwp_q[QA-1:0]] <= '{wr: req_write, addr: req_addr, data: req_data};
        if (s_hit)
            rmem_q[rwi_q] <= s_data;
    end
endmodule

// File: doc/r32_mem_port.md
Name: r32_mem_port

Overview:
- Parametrised memory-port block between the R32 core and the external request/response bus.
- Buffers core requests in a FIFO and drives them onto the m_* request channel with a valid/ready handshake.
- Limits in-flight reads with a credit counter and buffers read responses from the s_* channel for the core.
- All traffic is strictly in order; writes are posted and return no response.

Parameters:
ADDR_W  32  address width
DATA_W  32  data width
REQ_DEPTH  4  request FIFO entries; power of two, at least 2
MAX_RD  4  maximum reads in flight plus buffered, 1..16; also the response FIFO depth

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low; reset==0 resets the block on a rising clock edge
req_valid  in  1  core request valid
req_ready  out  1  request FIFO can accept
req_addr  in  ADDR_W  request address
req_data  in  DATA_W  write data, ignored for reads
req_write  in  1  1=write, 0=read
m_address  out  ADDR_W  bus request address
m_data  out  DATA_W  bus write data
m_write  out  1  bus request type
m_valid  out  1  bus request valid
m_ready  in  1  bus accepts request
s_data  in  DATA_W  bus read response data
s_valid  in  1  bus response valid
s_ready  out  1  block accepts response
rsp_valid  out  1  response to core valid
rsp_ready  in  1  core accepts response
rsp_data  out  DATA_W  response data
err  out  1  sticky spurious-response flag

Behaviour:
- Reset (reset==0 at an edge): both FIFOs are emptied and credit, inflight and err are cleared to 0. While reset==0, req_ready, m_valid, m_address, m_data, m_write, s_ready and rsp_valid are all driven 0.
- Request FIFO
  - req_ready = !req_full, computed from registered state only.
  - A push on a full FIFO is rejected even if a pop occurs in the same cycle.
  - A request accepted in cycle N reaches m_* no earlier than cycle N+1.
- Bus issue
  - The FIFO head is presented on m_*. m_valid=1 when the FIFO is non-empty and either the head is a write, or the head is a read and credit<MAX_RD.
  - Once m_valid=1, m_address, m_data, m_write and m_valid stay stable until m_ready=1 in that cycle.
  - The head pops on m_valid&&m_ready.
  - A read head blocked on credit also blocks writes behind it (head-of-line; no reordering).
- Credit accounting
  - credit increments when a read is issued (m_valid&&m_ready&&!m_write).
  - credit decrements when the core pops a response (rsp_valid&&rsp_ready).
  - Increment and decrement in the same cycle leave credit unchanged.
  - credit never exceeds MAX_RD. This guarantees the response FIFO cannot overflow.
- inflight counter
  - Increments on read issue and decrements on s_valid&&s_ready.
  - Both in the same cycle leave it unchanged.
- Response path
  - s_ready=1 whenever reset==1 and the response FIFO is not full; by construction it is never full while reads are pending.
  - A response accepted (s_valid&&s_ready) in cycle N is visible on rsp_valid/rsp_data in cycle N+1.
  - rsp_valid and rsp_data stay stable until rsp_ready.
  - A simultaneous push and pop on the response FIFO is allowed at any fill level.
- Spurious response: s_valid=1 while inflight==0 sets err=1 (sticky until reset). The beat is dropped and neither the FIFO nor credit changes.
- Counter widths: credit and inflight are clog2(MAX_RD+1) bits. FIFO pointers wrap modulo depth, with one extra bit for full/empty detection.
- Reset mid-operation: outstanding bus reads are forgotten. Any later responses to them are flagged as spurious via err.

Test Plan:
1. Reset/idle: hold reset=0 for 3 cycles with s_valid=1, then release -> err=0, m_valid=0, rsp_valid=0; req_ready=1 and s_ready=1 from the first cycle after release.
2. Write stream: push 4 writes (addr 0x10..0x13, data 0xAAAAAAAA) with m_ready=1 -> four m_valid beats in order starting 1 cycle after the first push; no rsp_valid.
3. Backpressure: push write addr 0x3 with m_ready=0 for 5 cycles -> m_valid=1 and m_address=0x3 stable throughout; 5th push rejected once FIFO holds 4.
4. Credit limit, MAX_RD=4: issue 5 reads with s_valid=0 and rsp_ready=0 -> exactly 4 issued, 5th held on m_*. Return 1 response and pop it -> 5th issues.
5. Response flow: read issued, then s_valid=1 with s_data=0x12345678 -> rsp_valid=1 with rsp_data=0x12345678 next cycle. Hold rsp_ready=0 for 3 cycles -> output stable.
6. Spurious response: s_valid=1 with no reads pending -> err=1 next cycle and stays 1. A subsequent write still issues normally.
